// File: rtl/snurisc_mem_arbiter_if.sv
// snurisc memory arbiter bus bundle.
// Groups the I$, D$ and backing-memory signals of the arbiter.
interface snurisc_mem_arbiter_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = AWIDTH
);
    logic              i_ic_rq;
    logic [AWIDTH-1:0] i_ic_addr;
    logic              o_ic_gnt;
    logic              o_ic_rvalid;
    logic [DWIDTH-1:0] o_ic_rdata;
    logic              o_ic_done;

    logic              i_dc_rq;
    logic              i_dc_rnw;
    logic [AWIDTH-1:0] i_dc_addr;
    logic [DWIDTH-1:0] i_dc_wdata;
    logic              o_dc_gnt;
    logic              o_dc_rvalid;
    logic [DWIDTH-1:0] o_dc_rdata;
    logic              o_dc_wready;
    logic              o_dc_done;

    logic              o_mem_rq;
    logic              o_mem_rnw;
    logic [AWIDTH-1:0] o_mem_addr;
    logic [DWIDTH-1:0] o_mem_wdata;
    logic              i_mem_ack;
    logic [DWIDTH-1:0] i_mem_rdata;

    modport master (
        input  i_ic_rq, i_ic_addr,
        output o_ic_gnt, o_ic_rvalid, o_ic_rdata, o_ic_done,
        input  i_dc_rq, i_dc_rnw, i_dc_addr, i_dc_wdata,
        output o_dc_gnt, o_dc_rvalid, o_dc_rdata, o_dc_wready, o_dc_done,
        output o_mem_rq, o_mem_rnw, o_mem_addr, o_mem_wdata,
        input  i_mem_ack, i_mem_rdata
    );

    modport slave (
        output i_ic_rq, i_ic_addr,
        input  o_ic_gnt, o_ic_rvalid, o_ic_rdata, o_ic_done,
        output i_dc_rq, i_dc_rnw, i_dc_addr, i_dc_wdata,
        input  o_dc_gnt, o_dc_rvalid, o_dc_rdata, o_dc_wready, o_dc_done,
        input  o_mem_rq, o_mem_rnw, o_mem_addr, o_mem_wdata,
        output i_mem_ack, i_mem_rdata
    );
endinterface

// File: rtl/snurisc_mem_arbiter.sv
// snurisc memory arbiter: shares one memory port between I$ and D$.
// Round-robin grant on ties, fixed-length line bursts over req/ack.
module snurisc_mem_arbiter #(
    parameter int AWIDTH     = 32,
    parameter int DWIDTH     = AWIDTH,
    parameter int LINE_WORDS = 4
) (
    input logic                   i_clk,
    input logic                   i_reset,
    snurisc_mem_arbiter_if.master bus
);
    localparam int BW    = $clog2(LINE_WORDS);
    localparam int BYTES = DWIDTH / 8;
    localparam int BSH   = $clog2(BYTES);
    localparam int OFFW  = $clog2(LINE_WORDS * BYTES);
    localparam logic [AWIDTH-1:0] OFF_MASK =
        {{(AWIDTH-OFFW){1'b0}}, {OFFW{1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        IC_BURST,
        DC_BURST
    } state_e;

    state_e            state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              last_dc_q, last_dc_d;
    logic [AWIDTH-1:0] base_q, base_d;
    logic              rnw_q, rnw_d;
    logic              ic_rvalid_q, ic_rvalid_d;
    logic [DWIDTH-1:0] ic_rdata_q, ic_rdata_d;
    logic              ic_done_q, ic_done_d;
    logic              dc_rvalid_q, dc_rvalid_d;
    logic [DWIDTH-1:0] dc_rdata_q, dc_rdata_d;
    logic              dc_done_q, dc_done_d;

    logic              ic_gnt, dc_gnt;
    logic              ic_win, dc_win;
    logic              last_beat;
    logic              mem_rq, mem_rnw, dc_wready;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;

    // State and registered response outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            last_dc_q   <= 1'b0;
            base_q      <= '0;
            rnw_q       <= 1'b0;
            ic_rvalid_q <= 1'b0;
            ic_rdata_q  <= '0;
            ic_done_q   <= 1'b0;
            dc_rvalid_q <= 1'b0;
            dc_rdata_q  <= '0;
            dc_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            last_dc_q   <= last_dc_d;
            base_q      <= base_d;
            rnw_q       <= rnw_d;
            ic_rvalid_q <= ic_rvalid_d;
            ic_rdata_q  <= ic_rdata_d;
            ic_done_q   <= ic_done_d;
            dc_rvalid_q <= dc_rvalid_d;
            dc_rdata_q  <= dc_rdata_d;
            dc_done_q   <= dc_done_d;
        end
    end

    // Arbitration, burst sequencing and memory-side outputs.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        last_dc_d   = last_dc_q;
        base_d      = base_q;
        rnw_d       = rnw_q;
        ic_rvalid_d = 1'b0;
        ic_rdata_d  = '0;
        ic_done_d   = 1'b0;
        dc_rvalid_d = 1'b0;
        dc_rdata_d  = '0;
        dc_done_d   = 1'b0;
        ic_gnt      = 1'b0;
        dc_gnt      = 1'b0;
        ic_win      = 1'b0;
        dc_win      = 1'b0;
        mem_rq      = 1'b0;
        mem_rnw     = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        dc_wready   = 1'b0;
        last_beat   = (beat_q == {BW{1'b1}});

        unique case (state_q)
            IDLE: begin
                // A done pulse still in flight holds off the next grant.
                if (!(ic_done_q || dc_done_q)) begin
                    dc_win = bus.i_dc_rq && (!bus.i_ic_rq || !last_dc_q);
                    ic_win = bus.i_ic_rq && !dc_win;
                end
                if (dc_win) begin
                    dc_gnt    = 1'b1;
                    base_d    = bus.i_dc_addr & ~OFF_MASK;
                    rnw_d     = bus.i_dc_rnw;
                    beat_d    = '0;
                    last_dc_d = 1'b1;
                    state_d   = DC_BURST;
                end else if (ic_win) begin
                    ic_gnt    = 1'b1;
                    base_d    = bus.i_ic_addr & ~OFF_MASK;
                    rnw_d     = 1'b1;
                    beat_d    = '0;
                    last_dc_d = 1'b0;
                    state_d   = IC_BURST;
                end
            end
            IC_BURST, DC_BURST: begin
                mem_rq   = 1'b1;
                mem_rnw  = rnw_q;
                mem_addr = base_q + (AWIDTH'(beat_q) << BSH);
                if (state_q == DC_BURST) begin
                    mem_wdata = bus.i_dc_wdata;
                    dc_wready = bus.i_mem_ack && !rnw_q;
                end
                if (bus.i_mem_ack) begin
                    beat_d = beat_q + BW'(1);
                    if (rnw_q) begin
                        if (state_q == IC_BURST) begin
                            ic_rvalid_d = 1'b1;
                            ic_rdata_d  = bus.i_mem_rdata;
                        end else begin
                            dc_rvalid_d = 1'b1;
                            dc_rdata_d  = bus.i_mem_rdata;
                        end
                    end
                    if (last_beat) begin
                        ic_done_d = (state_q == IC_BURST);
                        dc_done_d = (state_q == DC_BURST);
                        beat_d    = '0;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_ic_gnt    = ic_gnt && !i_reset;
    assign bus.o_ic_rvalid = ic_rvalid_q;
    assign bus.o_ic_rdata  = ic_rdata_q;
    assign bus.o_ic_done   = ic_done_q;
    assign bus.o_dc_gnt    = dc_gnt && !i_reset;
    assign bus.o_dc_rvalid = dc_rvalid_q;
    assign bus.o_dc_rdata  = dc_rdata_q;
    assign bus.o_dc_wready = dc_wready;
    assign bus.o_dc_done   = dc_done_q;
    assign bus.o_mem_rq    = mem_rq;
    assign bus.o_mem_rnw   = mem_rnw;
    assign bus.o_mem_addr  = mem_addr;
    assign bus.o_mem_wdata = mem_wdata;
endmodule

// File: doc/snurisc_mem_arbiter.md
Name: snurisc_mem_arbiter

Overview:
- Shares the single backing-memory port between the I$ refill path (frontend) and the D$ refill/writeback path of the snurisc SoC.
- Grants one requester at a time and sequences a fixed-length line burst of LINE_WORDS beats over a req/ack memory handshake.
- Returns read data to the granted cache.
- Sits between the caches and the memory model in the top-level SoC.

Parameters:
- AWIDTH, 32: address width in bits.
- DWIDTH, AWIDTH: data width in bits; one beat is one word of DWIDTH/8 bytes.
- LINE_WORDS, 4: beats per burst; must be a power of two and at least 2.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_ic_rq  in  1  I$ refill request; held high until o_ic_done.
- i_ic_addr  in  AWIDTH  I$ miss address.
- o_ic_gnt  out  1  one-cycle pulse when the I$ burst starts.
- o_ic_rvalid  out  1  I$ read beat valid.
- o_ic_rdata  out  DWIDTH  I$ read beat data.
- o_ic_done  out  1  one-cycle pulse with the final I$ beat.
- i_dc_rq  in  1  D$ request; held high until o_dc_done.
- i_dc_rnw  in  1  1 = refill (read), 0 = writeback (write).
- i_dc_addr  in  AWIDTH  D$ line address.
- i_dc_wdata  in  DWIDTH  current writeback word.
- o_dc_gnt  out  1  one-cycle pulse when the D$ burst starts.
- o_dc_rvalid  out  1  D$ read beat valid.
- o_dc_rdata  out  DWIDTH  D$ read beat data.
- o_dc_wready  out  1  writeback word consumed; D$ presents the next word.
- o_dc_done  out  1  one-cycle pulse at the end of the D$ burst.
- o_mem_rq  out  1  memory beat request.
- o_mem_rnw  out  1  memory beat direction.
- o_mem_addr  out  AWIDTH  memory beat address.
- o_mem_wdata  out  DWIDTH  memory write data.
- i_mem_ack  in  1  memory beat complete; read data valid in the same cycle.
- i_mem_rdata  in  DWIDTH  memory read data.

Behaviour:
- FSM states are IDLE, IC_BURST, DC_BURST. The beat counter is log2(LINE_WORDS) bits wide.
- Reset (asynchronous, any time, including mid-burst):
  - state = IDLE, beat counter = 0, last-served flag = IC, captured base address = 0.
  - All outputs 0; no pending burst is resumed.
- Arbitration in IDLE:
  - Only one requester high: that requester wins.
  - Both high: the one not served last wins. After reset the D$ wins the first tie.
  - On a win: pulse the winner's gnt for that single cycle. Capture base = addr with the low log2(LINE_WORDS*DWIDTH/8) bits cleared. Capture rnw, forced to 1 for I$. Set beat = 0, enter the burst state, and update last-served.
- Burst:
  - o_mem_rq = 1.
  - o_mem_addr = base + beat*(DWIDTH/8).
  - o_mem_rnw = captured rnw.
  - o_mem_wdata = i_dc_wdata (combinational pass-through).
  - A beat completes on a cycle with i_mem_ack = 1, and beat then increments. The memory may stall arbitrarily; rq, addr and rnw stay stable until ack.
- Read beat:
  - rvalid and rdata are registered: they assert the cycle after ack, carrying that ack's rdata, routed only to the granted requester.
  - done pulses together with the last rvalid.
- Write beat:
  - o_dc_wready = i_mem_ack (combinational) during DC_BURST writes.
  - o_dc_done is registered and pulses the cycle after the final ack.
- Burst exit: after the final ack, state returns to IDLE. The earliest next grant is the cycle after done, which guarantees a one-cycle bubble. Latency from request to first mem rq is 1 cycle.
- Boundary cases:
  - A requester dropping rq mid-burst is ignored; the burst runs to completion.
  - i_mem_ack while o_mem_rq = 0 is ignored.
  - The base address wraps modulo 2^AWIDTH. The beat counter never wraps inside a burst.
  - A new request arriving during a burst waits in IDLE arbitration.
  - Non-granted outputs stay 0 throughout.

Test Plan:
- I$ only, addr 0x0000_1234, ack every cycle, rdata 0xA0..0xA3:
  - o_mem_addr sequence is 0x1230, 0x1234, 0x1238, 0x123C.
  - o_ic_rvalid runs 4 consecutive cycles with data A0..A3; o_ic_done coincides with A3; o_dc_* stay 0.
- Both rq high immediately after reset:
  - D$ is granted first.
  - I$ gnt occurs exactly 2 cycles after o_dc_done's final ack cycle (one IDLE bubble).
  - On a later tie, I$ wins again only if D$ was served last.
- D$ writeback at 0x8000_0010, wdata 0x11..0x44, ack every other cycle:
  - o_mem_rnw = 0.
  - 4 o_dc_wready pulses, aligned with the acks.
  - o_mem_wdata matches the stream; o_dc_done fires the cycle after the 4th ack.
- Memory stall, no ack for 5 cycles on beat 2:
  - o_mem_addr is held at base+8 and o_mem_rq stays high.
  - No rvalid occurs until the ack.
- Reset asserted at beat 1 of an I$ burst:
  - All outputs are 0 immediately (asynchronous).
  - After release with i_dc_rq = 1, the D$ burst starts at beat 0.
- I$ drops rq at beat 1:
  - All 4 beats still issue and o_ic_done still pulses.
